// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, registered result and flags.
// Optional iterative multiplier on op 111 is enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             zero,
   output logic             equal,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   localparam logic [2:0] OpAnd = 3'b000;
   localparam logic [2:0] OpAdd = 3'b001;
   localparam logic [2:0] OpSub = 3'b010;
   localparam logic [2:0] OpSlt = 3'b011;
   localparam logic [2:0] OpSrl = 3'b100;
   localparam logic [2:0] OpSra = 3'b101;
   localparam logic [2:0] OpSll = 3'b110;
   localparam logic [2:0] OpMul = 3'b111;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             zero_q, zero_d;
   logic             equal_q, equal_d;
   logic             overflow_q, overflow_d;

   logic [WIDTH-1:0]   sum, diff, alu_z;
   logic               add_ovf, sub_ovf, alu_ovf, alu_rsvd;
   logic [SHAMT_W-1:0] shamt;
   logic               take_in, take_out, alu_wr;

`ifdef ALU_SEQ_MUL_EN
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mul_eq_q, mul_eq_d;

   assign busy     = (state_q == StMul);
   assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
`else
   assign busy     = 1'b0;
   assign in_ready = !out_valid_q || out_ready;
`endif

   assign take_in  = in_valid && in_ready;
   assign take_out = out_valid_q && out_ready;
   assign shamt    = y[SHAMT_W-1:0];

   // Single-cycle datapath for everything except the iterative multiply.
   always_comb begin
      sum      = x + y;
      diff     = x - y;
      add_ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      sub_ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      alu_z    = '0;
      alu_ovf  = 1'b0;
      alu_rsvd = 1'b0;
      case (op)
         OpAnd: alu_z = x & y;
         OpAdd: begin
            alu_z   = sum;
            alu_ovf = add_ovf;
         end
         OpSub: begin
            alu_z   = diff;
            alu_ovf = sub_ovf;
         end
         OpSlt: alu_z = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
         OpSrl: alu_z = x >> shamt;
         OpSra: alu_z = $signed(x) >>> shamt;
         OpSll: alu_z = x << shamt;
         default: alu_rsvd = 1'b1;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      z_d         = z_q;
      zero_d      = zero_q;
      equal_d     = equal_q;
      overflow_d  = overflow_q;
`ifdef ALU_SEQ_MUL_EN
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      mul_eq_d = mul_eq_q;
      alu_wr   = take_in && (op != OpMul);
`else
      alu_wr   = take_in;
`endif

      if (take_out) begin
         out_valid_d = 1'b0;
      end

      if (alu_wr) begin
         out_valid_d = 1'b1;
         z_d         = alu_z;
         zero_d      = !alu_rsvd && (alu_z == '0);
         equal_d     = !alu_rsvd && (x == y);
         overflow_d  = alu_ovf;
      end

`ifdef ALU_SEQ_MUL_EN
      if (take_in && (op == OpMul)) begin
         state_d  = StMul;
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, x};
         mplier_d = y;
         cnt_d    = '0;
         mul_eq_d = (x == y);
      end

      // WIDTH add/shift steps, then one cycle to publish the product.
      if (state_q == StMul) begin
         if (cnt_q == CNT_W'(WIDTH)) begin
            state_d     = StIdle;
            out_valid_d = 1'b1;
            z_d         = acc_q[WIDTH-1:0];
            zero_d      = (acc_q[WIDTH-1:0] == '0);
            equal_d     = mul_eq_q;
            overflow_d  = |acc_q[2*WIDTH-1:WIDTH];
         end else begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         z_q         <= '0;
         zero_q      <= 1'b0;
         equal_q     <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         state_q     <= StIdle;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         mul_eq_q    <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         zero_q      <= zero_d;
         equal_q     <= equal_d;
         overflow_q  <= overflow_d;
`ifdef ALU_SEQ_MUL_EN
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
         mul_eq_q    <= mul_eq_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign zero      = zero_q;
   assign equal     = equal_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner vectors plus randomized traffic,
// checked against a behavioural model; MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  x, y;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  z;
   logic          zero, equal, overflow, busy;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .zero      (zero),
      .equal     (equal),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] z;
      logic        zero;
      logic        eq;
      logic        ovf;
   } res_t;

   res_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   last_wait;
   bit   rnd_on   = 1'b0;
   bit   busy_seen = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic res_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      res_t               r;
      longint             s;
      int                 s32;
      int                 sh;
      logic signed [31:0] t;
      logic [63:0]        p;
      sh    = int'(b[4:0]);
      r.z   = '0;
      r.eq  = (a == b);
      r.ovf = 1'b0;
      case (o)
         3'd0: r.z = a & b;
         3'd1, 3'd2: begin
            s     = (o == 3'd1) ? longint'($signed(a)) + longint'($signed(b))
                                : longint'($signed(a)) - longint'($signed(b));
            s32   = int'(s);
            r.z   = s32;
            r.ovf = (longint'(s32) != s);
         end
         3'd3: r.z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd4: r.z = a >> sh;
         3'd5: begin
            t   = a;
            r.z = t >>> sh;
         end
         3'd6: r.z = a << sh;
         default: begin
`ifdef ALU_SEQ_MUL_EN
            p     = {32'b0, a} * {32'b0, b};
            r.z   = p[31:0];
            r.ovf = (p[63:32] != 32'd0);
`else
            p     = '0;
            r.eq  = 1'b0;
`endif
         end
      endcase
      r.zero = (r.z == 32'd0);
`ifndef ALU_SEQ_MUL_EN
      if (o == 3'd7) r.zero = 1'b0;
`endif
      return r;
   endfunction

   // Present one op, hold until accepted (bounded), push the expectation.
   task automatic send_raw(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input bit push, input res_t e);
      bit done = 1'b0;
      in_valid = 1'b1;
      op = o;
      x  = a;
      y  = b;
      last_wait = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) exp_q.push_back(e);
            done = 1'b1;
         end else begin
            last_wait++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      send_raw(o, a, b, 1'b1, model(o, a, b));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: pops on every transfer out, and checks hold-stability while stalled.
   initial begin
      res_t got, held;
      res_t e;
      bit   stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         got = {z, zero, equal, overflow};
         if (busy) busy_seen = 1'b1;
         if (stall_prev) begin
            chk("stall_hold", {28'd0, out_valid, got}, {28'd0, 1'b1, held});
         end
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("result", got, e);
            end
         end
         stall_prev = !rst && out_valid && !out_ready;
         held = got;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_on) out_ready = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      int k;
      logic [31:0] a, b;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x = '0;
      y = '0;
      op = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_state", {z, out_valid, zero, equal, overflow, busy, in_ready},
          {32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

      send_raw(3'd1, 32'h7FFF_FFFF, 32'h1, 1'b1, '{32'h8000_0000, 1'b0, 1'b0, 1'b1});
      chk("add_latency", {63'd0, out_valid}, 64'd1);
      send_raw(3'd2, 32'h1234, 32'h1234, 1'b1, '{32'h0, 1'b1, 1'b1, 1'b0});
      send_raw(3'd3, 32'hFFFF_FFFF, 32'h1, 1'b1, '{32'h1, 1'b0, 1'b0, 1'b0});
      send_raw(3'd5, 32'h8000_0000, 32'h1F, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      send_raw(3'd6, 32'h1, 32'h21, 1'b1, '{32'h2, 1'b0, 1'b0, 1'b0});
      send_raw(3'd4, 32'hA5A5_F00F, 32'h20, 1'b1, '{32'hA5A5_F00F, 1'b0, 1'b0, 1'b0});
`ifndef ALU_SEQ_MUL_EN
      send_raw(3'd7, 32'h5, 32'h5, 1'b1, '{32'h0, 1'b0, 1'b0, 1'b0});
      chk("rsvd_latency_busy", {62'd0, out_valid, busy}, {62'd0, 1'b1, 1'b0});
`endif
      @(posedge clk);
      #1;

      // Stall for five cycles, then drain and accept on the same edge.
      out_ready = 1'b0;
      send(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("stall_ready", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, 1'b1});
      end
      out_ready = 1'b1;
      send(3'd1, 32'd100, 32'd23);
      chk("drain_accept_wait", 64'(last_wait), 64'd0);
      send(3'd2, 32'd5, 32'd9);
      chk("back_to_back_wait", {31'd0, out_valid, 32'(last_wait)}, {31'd0, 1'b1, 32'd0});

`ifdef ALU_SEQ_MUL_EN
      send_raw(3'd7, 32'h1_0000, 32'h1_0001, 1'b1, '{32'h1_0000, 1'b0, 1'b0, 1'b1});
      chk("mul_busy", {62'd0, busy, in_ready}, {62'd0, 1'b1, 1'b0});
      k = 0;
      for (int i = 1; i <= 100 && k == 0; i++) begin
         x = $urandom;
         y = $urandom;
         @(posedge clk);
         #1;
         if (out_valid) k = i;
      end
      chk("mul_latency", 64'(k), 64'd33);

      send_raw(3'd7, 32'h123, 32'h456, 1'b0, '{32'h0, 1'b0, 1'b0, 1'b0});
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mul_abort", {61'd0, out_valid, busy, in_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
      repeat (40) @(posedge clk);
      #1;
      chk("mul_abort_quiet", {63'd0, out_valid}, 64'd0);
`endif

      rnd_on = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         a = pick();
         b = ($urandom_range(0, 5) == 0) ? a : pick();
         send(3'($urandom_range(0, 7)), a, b);
      end
      rnd_on    = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
`ifndef ALU_SEQ_MUL_EN
      chk("busy_never", {63'd0, busy_seen}, 64'd0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Derived localparam SHAMT_W = log2(WIDTH), the shift-amount width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  operand/op presented this cycle.
REQ-006 in_ready  out  1  block accepts operands this cycle.
REQ-007 x  in  WIDTH  first operand.
REQ-008 y  in  WIDTH  second operand; y[SHAMT_W-1:0] is the shift amount.
REQ-009 op  in  3  opcode: 000 AND, 001 ADD, 010 SUB, 011 SLT, 100 SRL, 101 SRA, 110 SLL, 111 MUL/reserved.
REQ-010 out_valid  out  1  result register holds a valid result.
REQ-011 out_ready  in  1  consumer takes the result this cycle.
REQ-012 z  out  WIDTH  registered result.
REQ-013 zero, equal, overflow  out  1 each  registered flags for the result in z.
REQ-014 busy  out  1  FSM not in IDLE.

Function
REQ-015 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-016 FSM states IDLE, MUL; IDLE->MUL on accepted op 111 (MUL_EN only); MUL->IDLE after the last iteration; otherwise hold.
REQ-017 in_ready = (state == IDLE) && (!out_valid || out_ready); same-cycle drain and accept is legal, giving 1 op/cycle throughput.
REQ-018 Ops 000-110 and reserved 111: result, flags and out_valid registered on the accepting edge; out_valid high the following cycle (latency 1).
REQ-019 z, flags and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-020 out_valid SHALL clear after a transfer out with no new result written the same edge.
REQ-021 ADD/SUB: two's-complement x+y / x-y modulo 2^WIDTH; overflow = signed overflow.
REQ-022 SLT: z = 1 if signed x < y (sign of x-y XOR signed overflow), else 0.
REQ-023 SRL/SRA/SLL: shift x by y[SHAMT_W-1:0]; SRA sign-fills; shamt 0 returns x unchanged.
REQ-024 zero = (z == 0); equal = (x == y) for the accepted operands; overflow = 0 for all ops except ADD, SUB, MUL.
REQ-025 Reserved op: z = 0, zero = equal = overflow = 0.
REQ-026 MUL uses unsigned shift-and-add, one multiplier bit per cycle, WIDTH iterations in state MUL.
REQ-027 MUL z = low WIDTH bits of x*y; overflow = 1 if any bit of the upper WIDTH product bits is nonzero.
REQ-028 MUL out_valid rises exactly WIDTH+1 cycles after the accepting edge; in_ready = 0 throughout MUL.
REQ-029 Operands SHALL be captured on the accepting edge; input changes during MUL do not affect the result.

Reset
REQ-030 On rst: state = IDLE, out_valid = 0, z = 0, zero = equal = overflow = 0, busy = 0, multiply accumulator cleared.
REQ-031 rst during MUL aborts the operation; no result is produced.
REQ-032 rst has priority over any simultaneous transfer in or out.

Configuration
REQ-033 Macro ALU_SEQ_MUL_EN: when defined, op 111 is MUL per REQ-026..REQ-028.
REQ-034 When ALU_SEQ_MUL_EN is undefined, op 111 is reserved per REQ-025 with latency 1, the MUL state and multiplier logic are absent, and busy is constant 0.

Verification
REQ-035 WIDTH=32, ADD x=0x7FFFFFFF y=1, out_ready=1 -> next cycle out_valid=1, z=0x80000000, overflow=1, zero=0.
REQ-036 SUB x=y=0x1234 -> z=0, zero=1, equal=1, overflow=0; SLT x=0xFFFFFFFF y=1 -> z=1.
REQ-037 SRA x=0x80000000 y=0x1F -> z=0xFFFFFFFF; SLL x=1 y=0x21 -> z=2; SRL shamt 0 -> z=x.
REQ-038 out_ready=0 for 5 cycles after an AND result -> z, flags, out_valid stable, in_ready=0; out_ready=1 with in_valid=1 -> drain and accept same edge, back-to-back results.
REQ-039 MUL_EN, MUL x=0x10000 y=0x10001 -> out_valid after 33 cycles, z=0x10000, overflow=1; rst asserted at iteration 10 -> out_valid stays 0, busy=0, in_ready=1 next cycle.
REQ-040 Without MUL_EN, op 111 -> latency 1, z=0, all flags 0, busy never asserted.
